// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: two prioritised write ports, two combinational
// read ports with optional write-to-read bypass, hardwired zero register and a clear sequencer.
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_req,
    input  logic             we_a,
    input  logic [AW-1:0]    waddr_a,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic             we_b,
    input  logic [AW-1:0]    waddr_b,
    input  logic [WIDTH-1:0] wdata_b,
    input  logic [AW-1:0]    raddr_1,
    input  logic [AW-1:0]    raddr_2,
    output logic [WIDTH-1:0] rdata_1,
    output logic [WIDTH-1:0] rdata_2,
    output logic             busy,
    output logic             clear_done
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] registers [DEPTH];
    logic             wr_a;
    logic             wr_b;
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    assign busy = (state == ST_CLEAR);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement or block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == LAST_ADDR) begin
                        state      <= ST_IDLE;
                        clear_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign wr_a = !busy && we_a && !(ZERO_REG && (waddr_a == '0));
    assign wr_b = !busy && we_b && !(ZERO_REG && (waddr_b == '0));

    // NOTE: the array deliberately has no reset so it can map onto RAM; the clear
    // sequencer zeroes it instead. Port B is written last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (busy) begin
            registers[cnt] <= '0;
        end else begin
            if (wr_a) registers[waddr_a] <= wdata_a;
            if (wr_b) registers[waddr_b] <= wdata_b;
        end
    end

    assign raddr[0] = raddr_1;
    assign raddr[1] = raddr_2;

    // NOTE: each read value gets a default before the overrides, so no latch can be inferred.
    // Later assignments take priority: busy, then zero register, then bypass, then array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = registers[raddr[p]];
            if (BYPASS) begin
                if (we_b && (waddr_b == raddr[p])) begin
                    rdata[p] = wdata_b;
                end else if (we_a && (waddr_a == raddr[p])) begin
                    rdata[p] = wdata_a;
                end
            end
            if (ZERO_REG && (raddr[p] == '0)) rdata[p] = '0;
            if (busy) rdata[p] = '0;
        end
    end

    assign rdata_1 = rdata[0];
    assign rdata_2 = rdata[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed scoreboard bench for reg_file_mp: 32x32 without and with bypass sharing stimulus,
// plus a 16x8 instance without a zero register.
module tb_reg_file_mp;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   a_done_pulses = 0;
    int   pulses0 = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        we_a = 1'b0, we_b = 1'b0;
    logic [4:0]  waddr_a = '0, waddr_b = '0, raddr_1 = '0, raddr_2 = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0;
    logic [31:0] a_rdata_1, a_rdata_2, b_rdata_1, b_rdata_2;
    logic        a_busy, a_clear_done, b_busy, b_clear_done;

    logic        c_clear_req = 1'b0;
    logic        c_we_a = 1'b0, c_we_b = 1'b0;
    logic [3:0]  c_waddr_a = '0, c_waddr_b = '0, c_raddr_1 = '0, c_raddr_2 = '0;
    logic [7:0]  c_wdata_a = '0, c_wdata_b = '0;
    logic [7:0]  c_rdata_1, c_rdata_2;
    logic        c_busy, c_clear_done;

    always #5 clk = ~clk;

    reg_file_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .raddr_1(raddr_1), .raddr_2(raddr_2),
        .rdata_1(a_rdata_1), .rdata_2(a_rdata_2),
        .busy(a_busy), .clear_done(a_clear_done)
    );

    reg_file_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .raddr_1(raddr_1), .raddr_2(raddr_2),
        .rdata_1(b_rdata_1), .rdata_2(b_rdata_2),
        .busy(b_busy), .clear_done(b_clear_done)
    );

    reg_file_mp #(.WIDTH(8), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_c (
        .clk(clk), .rst(rst), .clear_req(c_clear_req),
        .we_a(c_we_a), .waddr_a(c_waddr_a), .wdata_a(c_wdata_a),
        .we_b(c_we_b), .waddr_b(c_waddr_b), .wdata_b(c_wdata_b),
        .raddr_1(c_raddr_1), .raddr_2(c_raddr_2),
        .rdata_1(c_rdata_1), .rdata_2(c_rdata_2),
        .busy(c_busy), .clear_done(c_clear_done)
    );

    always @(negedge clk) if (a_clear_done === 1'b1) a_done_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            raddr_1 = 5'(i);
            raddr_2 = 5'(31 - i);
            push_exp({tag, "_a1"}, 32'h0);
            push_exp({tag, "_a2"}, 32'h0);
            push_exp({tag, "_b1"}, 32'h0);
            push_exp({tag, "_b2"}, 32'h0);
            #1;
            check(a_rdata_1);
            check(a_rdata_2);
            check(b_rdata_1);
            check(b_rdata_2);
        end
    endtask

    initial begin
        // Reset values while rst is held
        step();
        step();
        raddr_1 = 5'd5;
        c_raddr_1 = 4'd3;
        push_exp("rst_a_busy", 32'h1);
        push_exp("rst_a_done", 32'h0);
        push_exp("rst_a_rdata_1", 32'h0);
        push_exp("rst_c_busy", 32'h1);
        push_exp("rst_c_rdata_1", 32'h0);
        #1;
        check(32'(a_busy));
        check(32'(a_clear_done));
        check(a_rdata_1);
        check(32'(c_busy));
        check(32'(c_rdata_1));

        // Release: 32-edge clear for dut_a, 16-edge clear for dut_c
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            push_exp($sformatf("rel_a_busy_%0d", k), 32'(k < 32));
            push_exp($sformatf("rel_a_done_%0d", k), 32'(k == 32));
            push_exp($sformatf("rel_c_busy_%0d", k), 32'(k < 16));
            push_exp($sformatf("rel_c_done_%0d", k), 32'(k == 16));
            check(32'(a_busy));
            check(32'(a_clear_done));
            check(32'(c_busy));
            check(32'(c_clear_done));
        end
        step();
        push_exp("rel_a_done_drop", 32'h0);
        check(32'(a_clear_done));
        check_all_zero("rel_zero");

        // dut_c: r0 is a normal register, then a 16-cycle clear
        c_we_a = 1'b1; c_waddr_a = 4'd0; c_wdata_a = 8'hA5; c_raddr_1 = 4'd0;
        push_exp("c_r0_same_cycle", 32'h0);
        #1;
        check(32'(c_rdata_1));
        step();
        c_we_a = 1'b0;
        push_exp("c_r0_next_cycle", 32'hA5);
        #1;
        check(32'(c_rdata_1));
        c_clear_req = 1'b1;
        step();
        c_clear_req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            push_exp($sformatf("c_clr_busy_%0d", k), 32'h1);
            #1;
            check(32'(c_busy));
            step();
        end
        push_exp("c_clr_busy_end", 32'h0);
        push_exp("c_clr_done_end", 32'h1);
        push_exp("c_clr_r0", 32'h0);
        #1;
        check(32'(c_busy));
        check(32'(c_clear_done));
        check(32'(c_rdata_1));

        // Write r5: old value in the write cycle without bypass, new value with bypass
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr_1 = 5'd5;
        push_exp("a_r5_same_cycle", 32'h0);
        push_exp("b_r5_bypass", 32'hDEADBEEF);
        #1;
        check(a_rdata_1);
        check(b_rdata_1);
        step();
        we_a = 1'b0;
        push_exp("a_r5_next_cycle", 32'hDEADBEEF);
        #1;
        check(a_rdata_1);

        // Write to r0 is dropped, and the zero register beats bypass
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1234; raddr_2 = 5'd0;
        push_exp("b_r0_bypass_zero", 32'h0);
        #1;
        check(b_rdata_2);
        step();
        we_a = 1'b0;
        push_exp("a_r0_after_write", 32'h0);
        #1;
        check(a_rdata_2);

        // Same-address dual write: B wins, both read ports on the same address
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h1111;
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h2222;
        raddr_1 = 5'd7; raddr_2 = 5'd7;
        push_exp("b_r7_bypass_1", 32'h2222);
        push_exp("b_r7_bypass_2", 32'h2222);
        push_exp("a_r7_same_cycle", 32'h0);
        #1;
        check(b_rdata_1);
        check(b_rdata_2);
        check(a_rdata_1);
        step();
        we_a = 1'b0; we_b = 1'b0;
        push_exp("a_r7_dual_1", 32'h2222);
        push_exp("a_r7_dual_2", 32'h2222);
        #1;
        check(a_rdata_1);
        check(a_rdata_2);

        // Distinct-address dual write
        we_a = 1'b1; waddr_a = 5'd9;  wdata_a = 32'h0000_0009;
        we_b = 1'b1; waddr_b = 5'd10; wdata_b = 32'h0000_000A;
        raddr_1 = 5'd9; raddr_2 = 5'd10;
        push_exp("b_r9_bypass_a", 32'h9);
        push_exp("b_r10_bypass_b", 32'hA);
        #1;
        check(b_rdata_1);
        check(b_rdata_2);
        step();
        we_a = 1'b0; we_b = 1'b0;
        push_exp("a_r9", 32'h9);
        push_exp("a_r10", 32'hA);
        #1;
        check(a_rdata_1);
        check(a_rdata_2);

        // Fill every register with address+1
        for (int i = 0; i < 32; i += 2) begin
            we_a = 1'b1; waddr_a = 5'(i);     wdata_a = 32'(i + 1);
            we_b = 1'b1; waddr_b = 5'(i + 1); wdata_b = 32'(i + 2);
            step();
        end
        we_a = 1'b0; we_b = 1'b0;
        raddr_1 = 5'd31; raddr_2 = 5'd1;
        push_exp("fill_r31", 32'd32);
        push_exp("fill_r1", 32'd2);
        #1;
        check(a_rdata_1);
        check(a_rdata_2);
        raddr_1 = 5'd3; raddr_2 = 5'd0;
        push_exp("fill_r3", 32'd4);
        push_exp("fill_r0_zero", 32'h0);
        #1;
        check(a_rdata_1);
        check(a_rdata_2);

        // Clear request with a same-edge write, writes to r3 and a repeated request during clear
        clear_req = 1'b1;
        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h77;
        step();
        clear_req = 1'b0;
        wdata_a = 32'hBAD;
        raddr_1 = 5'd3; raddr_2 = 5'd31;
        for (int k = 1; k <= 32; k++) begin
            clear_req = (k == 10);
            push_exp($sformatf("clr_a_busy_%0d", k), 32'h1);
            push_exp($sformatf("clr_a_r3_%0d", k), 32'h0);
            push_exp($sformatf("clr_a_r31_%0d", k), 32'h0);
            push_exp($sformatf("clr_b_r3_%0d", k), 32'h0);
            #1;
            check(32'(a_busy));
            check(a_rdata_1);
            check(a_rdata_2);
            check(b_rdata_1);
            step();
        end
        clear_req = 1'b0;
        we_a = 1'b0;
        push_exp("clr_a_busy_end", 32'h0);
        push_exp("clr_a_done_end", 32'h1);
        #1;
        check(32'(a_busy));
        check(32'(a_clear_done));
        check_all_zero("clr_zero");

        // Reset at clear cycle 10 restarts a full clear with one done pulse
        pulses0 = a_done_pulses;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        push_exp("mid_rst_busy", 32'h1);
        push_exp("mid_rst_done", 32'h0);
        #1;
        check(32'(a_busy));
        check(32'(a_clear_done));
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            push_exp($sformatf("mid_a_busy_%0d", k), 32'(k < 32));
            push_exp($sformatf("mid_a_done_%0d", k), 32'(k == 32));
            check(32'(a_busy));
            check(32'(a_clear_done));
        end
        step();
        push_exp("mid_done_pulses", 32'(pulses0 + 1));
        check(32'(a_done_pulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the MIPS datapath, replacing the fixed 32x32, 2-read/1-write register file. It provides two write ports with fixed priority, two combinational read ports with optional write-to-read bypass, and an optional hardwired-zero register. The storage array has no reset, so it can map to RAM. Contents are zeroed by an internal clear sequencer that runs after reset or on request and reports progress through `busy`.

## Interface
- `WIDTH`, 32: data bits per register.
- `DEPTH`, 32: number of registers; power of 2, at least 2.
- `AW`, $clog2(DEPTH): address width (derived; do not override).
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and ignores writes.
- `BYPASS`, 0: when 1, a read returns the data being written to the same address in the same cycle.

Ports (direction, width, meaning):
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `clear_req`, in, 1: one-cycle request to zero all registers.
- `we_a`, in, 1: write enable, port A.
- `waddr_a`, in, AW: write address, port A.
- `wdata_a`, in, WIDTH: write data, port A.
- `we_b`, in, 1: write enable, port B (higher priority than A).
- `waddr_b`, in, AW: write address, port B.
- `wdata_b`, in, WIDTH: write data, port B.
- `raddr_1`, in, AW: read address 1.
- `raddr_2`, in, AW: read address 2.
- `rdata_1`, out, WIDTH: read data 1 (combinational).
- `rdata_2`, out, WIDTH: read data 2 (combinational).
- `busy`, out, 1: clear sequence in progress.
- `clear_done`, out, 1: one-cycle pulse when a clear completes.

## Operation
- **State machine:** two states, CLEAR and IDLE, plus a counter `cnt` of AW bits.
- **Reset:** `rst` high immediately forces state to CLEAR, `cnt` to 0 and `clear_done` to 0. The array is not reset.
- **CLEAR state:** on each edge, `registers[cnt]` is written with 0 and `cnt` increments.
  - When `cnt == DEPTH-1`, the next state is IDLE and `clear_done` is 1 for the following cycle.
  - `cnt` wraps to 0.
- **IDLE state:** `clear_req` high moves to CLEAR, with `cnt` already 0.
  - `clear_req` is ignored while in CLEAR; the sequence is not restarted.
- **Busy flag:** `busy` = (state == CLEAR). It is decoded from the state and is 1 at reset.
- **Writes during CLEAR:** `we_a` and `we_b` are ignored entirely; no partial updates.
- **Writes in IDLE:**
  - Port A writes when `we_a` is high. Port B writes when `we_b` is high.
  - If both ports target the same address, B's data is stored.
  - If `ZERO_REG`=1, writes to address 0 are dropped.
- **Reads:**
  - `rdata_n` = 0 if `busy`.
  - Otherwise 0 if `ZERO_REG` and `raddr_n` == 0.
  - Otherwise, if `BYPASS`: `wdata_b` when `we_b` and `waddr_b` == `raddr_n`, else `wdata_a` when `we_a` and `waddr_a` == `raddr_n`.
  - Otherwise `registers[raddr_n]`.
- **Read independence:** reads never alter state; both ports may read the same address.

## Timing
- **Write-to-read latency:**
  - `BYPASS`=0: written data is visible on reads in the cycle after the write edge.
  - `BYPASS`=1: same cycle, combinationally.
- **Clear duration:** exactly DEPTH rising edges spent in CLEAR.
  - After `rst` falls, `busy` drops after the DEPTH-th rising edge.
  - After IDLE with `clear_req`, `busy` rises after one edge and stays high for DEPTH cycles.
- **`clear_done`:** high for exactly one cycle, coincident with the first cycle in which `busy` = 0.
- **Reset values:** `busy` = 1, `clear_done` = 0, `rdata_1` = `rdata_2` = 0.
- **Reset mid-clear:** the sequence restarts from `cnt` = 0.
- **`clear_req` in the same cycle as writes in IDLE:** the writes take effect on that edge, then the clear zeroes everything.

## Test plan
- **Reset release, DEPTH=32:**
  - Stimulus: release `rst`.
  - Required: `busy` high for 32 edges; `clear_done` pulses once; all 32 addresses then read 0.
- **Writes and zero register, BYPASS=0:**
  - Stimulus: write A `0xDEADBEEF` to r5; read r5 in the same cycle, then the next cycle; write `0x1234` to r0.
  - Required: r5 reads old value 0, then `0xDEADBEEF`; r0 reads 0.
- **Same-address dual write:**
  - Stimulus: A writes `0x1111` and B writes `0x2222`, both to r7.
  - Required: r7 = `0x2222`. With `BYPASS`=1, a same-cycle read of r7 returns `0x2222`.
- **Clear request:**
  - Stimulus: fill all registers with the address+1; pulse `clear_req`; attempt a write to r3 during the clear.
  - Required: `busy` for 32 cycles; reads 0 throughout; afterwards all registers read 0, including r3.
- **Reset mid-clear:**
  - Stimulus: assert `rst` at clear cycle 10.
  - Required: `busy` stays 1; a full 32-cycle clear follows; one `clear_done` pulse total.
- **ZERO_REG=0, DEPTH=16, WIDTH=8:**
  - Stimulus: write `0xA5` to r0.
  - Required: r0 reads `0xA5` next cycle; the clear takes 16 cycles.
